// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipeline stage buffer.
package pipe_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned OCC_W      = 2;

  typedef logic [OCC_W-1:0] occ_t;

  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_ONE   = 2'd1;
  localparam occ_t OCC_FULL  = 2'd2;

  // Source selected for the head slot on a given cycle.
  typedef enum logic [1:0] {
    SrcHold,
    SrcSkid,
    SrcPre,
    SrcClear
  } h_src_e;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot: valid bit plus payload with load, clear and synchronous reset.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned        DATA_W   = DEF_DATA_W,
  parameter logic [DATA_W-1:0]  RST_DATA = '0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic              clr,
  input  logic [DATA_W-1:0] din,
  output logic              valid,
  output logic [DATA_W-1:0] dout
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  // Payload only moves on load; clearing the valid bit leaves it untouched.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      data_q  <= RST_DATA;
    end else begin
      if (clr) begin
        valid_q <= 1'b0;
      end else if (load) begin
        valid_q <= 1'b1;
      end
      if (load) begin
        data_q <= din;
      end
    end
  end

  assign valid = valid_q;
  assign dout  = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage buffer with head slot and optional skid slot.
// Define PIPE_STAGE_SKID_EN to build the skid slot and a fully registered cur_allowin.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned        DATA_W   = DEF_DATA_W,
  parameter logic [DATA_W-1:0]  RST_DATA = '0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cur_stall,
  input  logic              flush,
  input  logic              pre_valid,
  input  logic [DATA_W-1:0] pre_data,
  output logic              cur_allowin,
  input  logic              post_allowin,
  output logic              goon_valid,
  output logic              reg_valid,
  output logic [DATA_W-1:0] data,
  output logic [OCC_W-1:0]  occupancy
);

  logic              hv;
  logic [DATA_W-1:0] hd;
  logic              sv;
  logic [DATA_W-1:0] sd;

  logic              accept;
  logic              issue;
  logic              h_free;
  h_src_e            h_src;
  logic              h_load;
  logic              h_clr;
  logic [DATA_W-1:0] h_din;

  assign goon_valid = hv && !cur_stall;
  assign issue      = goon_valid && post_allowin;
  assign accept     = pre_valid && cur_allowin;
  assign h_free     = issue || !hv;

  // Skid entry always has priority over fresh input to keep FIFO order.
  always_comb begin
    h_src = SrcHold;
    if (h_free) begin
      if (sv) begin
        h_src = SrcSkid;
      end else if (accept) begin
        h_src = SrcPre;
      end else begin
        h_src = SrcClear;
      end
    end
  end

  assign h_load = !flush && ((h_src == SrcSkid) || (h_src == SrcPre));
  assign h_clr  = flush || (h_src == SrcClear);
  assign h_din  = (h_src == SrcSkid) ? sd : pre_data;

  pipe_slot #(
    .DATA_W   (DATA_W),
    .RST_DATA (RST_DATA)
  ) u_head (
    .clk    (clk),
    .resetn (resetn),
    .load   (h_load),
    .clr    (h_clr),
    .din    (h_din),
    .valid  (hv),
    .dout   (hd)
  );

`ifdef PIPE_STAGE_SKID_EN
  logic s_load;
  logic s_clr;

  // Skid takes input when head is busy, or refills behind a skid->head move.
  assign s_load = !flush && accept && ((hv && !issue) || (h_src == SrcSkid));
  assign s_clr  = flush || ((h_src == SrcSkid) && !accept);

  pipe_slot #(
    .DATA_W   (DATA_W),
    .RST_DATA (RST_DATA)
  ) u_skid (
    .clk    (clk),
    .resetn (resetn),
    .load   (s_load),
    .clr    (s_clr),
    .din    (pre_data),
    .valid  (sv),
    .dout   (sd)
  );

  assign cur_allowin = !sv;
`else
  assign sv          = 1'b0;
  assign sd          = RST_DATA;
  assign cur_allowin = !hv || (!cur_stall && post_allowin);
`endif

  assign reg_valid = hv;
  assign data      = hd;

  always_comb begin
    occupancy = OCC_EMPTY;
    if (hv && sv) begin
      occupancy = OCC_FULL;
    end else if (hv) begin
      occupancy = OCC_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf against a queue-based reference model.
module tb_pipe_stage_buf;

  localparam logic [63:0] RST64 = 64'hCAFE_F00D_1234_5679;

`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        cur_stall;
  logic        flush;
  logic        pre_valid;
  logic        post_allowin;
  logic [63:0] pre_data64;

  logic        a_allow, a_goon, a_regv;
  logic [31:0] a_data;
  logic [1:0]  a_occ;
  logic        b_allow, b_goon, b_regv;
  logic [0:0]  b_data;
  logic [1:0]  b_occ;
  logic        c_allow, c_goon, c_regv;
  logic [63:0] c_data;
  logic [1:0]  c_occ;

  pipe_stage_buf #(.DATA_W(32), .RST_DATA(RST64[31:0])) dut (
    .clk(clk), .resetn(resetn), .cur_stall(cur_stall), .flush(flush),
    .pre_valid(pre_valid), .pre_data(pre_data64[31:0]), .cur_allowin(a_allow),
    .post_allowin(post_allowin), .goon_valid(a_goon), .reg_valid(a_regv),
    .data(a_data), .occupancy(a_occ)
  );

  pipe_stage_buf #(.DATA_W(1), .RST_DATA(RST64[0:0])) dut_w1 (
    .clk(clk), .resetn(resetn), .cur_stall(cur_stall), .flush(flush),
    .pre_valid(pre_valid), .pre_data(pre_data64[0:0]), .cur_allowin(b_allow),
    .post_allowin(post_allowin), .goon_valid(b_goon), .reg_valid(b_regv),
    .data(b_data), .occupancy(b_occ)
  );

  pipe_stage_buf #(.DATA_W(64), .RST_DATA(RST64)) dut_w64 (
    .clk(clk), .resetn(resetn), .cur_stall(cur_stall), .flush(flush),
    .pre_valid(pre_valid), .pre_data(pre_data64), .cur_allowin(c_allow),
    .post_allowin(post_allowin), .goon_valid(c_goon), .reg_valid(c_regv),
    .data(c_data), .occupancy(c_occ)
  );

  int          errors = 0;
  int          checks = 0;
  logic [63:0] q[$];
  logic [63:0] last_head = RST64;
  logic        last_acc = 1'b0;
  logic [63:0] src;

  // Check all outputs against the model, then advance one clock and update the model.
  task automatic step();
    logic        exp_allow;
    logic        exp_goon;
    logic [63:0] exp_data;
    logic        acc;
    logic        iss;
    int          n;
    #1;
    n = q.size();
`ifdef PIPE_STAGE_SKID_EN
    exp_allow = (n < CAP);
`else
    exp_allow = (n == 0) || (!cur_stall && post_allowin);
`endif
    exp_goon = (n > 0) && !cur_stall;
    exp_data = (n > 0) ? q[0] : last_head;

    checks++;
    if (a_allow !== exp_allow) begin
      errors++;
      $display("FAIL allowin t=%0t got=%b exp=%b", $time, a_allow, exp_allow);
    end
    checks++;
    if (a_goon !== exp_goon) begin
      errors++;
      $display("FAIL goon_valid t=%0t got=%b exp=%b", $time, a_goon, exp_goon);
    end
    checks++;
    if (a_regv !== (n > 0)) begin
      errors++;
      $display("FAIL reg_valid t=%0t got=%b exp=%b", $time, a_regv, (n > 0));
    end
    checks++;
    if (a_occ !== 2'(n)) begin
      errors++;
      $display("FAIL occupancy t=%0t got=%0d exp=%0d", $time, a_occ, n);
    end
    checks++;
    if (a_data !== exp_data[31:0]) begin
      errors++;
      $display("FAIL data32 t=%0t got=%h exp=%h", $time, a_data, exp_data[31:0]);
    end
    checks++;
    if (b_data !== exp_data[0:0] || b_occ !== 2'(n)) begin
      errors++;
      $display("FAIL w1 t=%0t got data=%b occ=%0d exp data=%b occ=%0d", $time, b_data, b_occ,
               exp_data[0], n);
    end
    checks++;
    if (c_data !== exp_data || c_occ !== 2'(n)) begin
      errors++;
      $display("FAIL w64 t=%0t got data=%h occ=%0d exp data=%h occ=%0d", $time, c_data, c_occ,
               exp_data, n);
    end

    acc = pre_valid && exp_allow;
    iss = exp_goon && post_allowin;
    @(posedge clk);
    if (!resetn) begin
      q.delete();
      last_head = RST64;
      acc = 1'b0;
    end else if (flush) begin
      q.delete();
      acc = 1'b0;
    end else begin
      if (iss) void'(q.pop_front());
      if (acc) q.push_back(pre_data64);
      if (q.size() > 0) last_head = q[0];
    end
    last_acc = acc;
    #1;
  endtask

  task automatic idle_drain(input int cycles);
    pre_valid = 1'b0; post_allowin = 1'b1; cur_stall = 1'b0; flush = 1'b0;
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic test_reset();
    resetn = 1'b0; cur_stall = 1'b1; flush = 1'b0; pre_valid = 1'b1;
    post_allowin = 1'b1; pre_data64 = 64'h1;
    @(posedge clk);
    #1;
    step();
    step();
    resetn = 1'b1; pre_valid = 1'b0; cur_stall = 1'b0;
    #1;
    checks++;
    if (a_data !== RST64[31:0] || a_occ !== 2'd0 || a_allow !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got data=%h occ=%0d allow=%b exp data=%h occ=0 allow=1",
               a_data, a_occ, a_allow, RST64[31:0]);
    end
    step();
  endtask

  task automatic test_first_entry();
    pre_valid = 1'b1; pre_data64 = 64'hA5; post_allowin = 1'b1;
    step();
    checks++;
    if (a_data !== 32'hA5 || a_goon !== 1'b1 || a_occ !== 2'd1) begin
      errors++;
      $display("FAIL first_entry got data=%h goon=%b occ=%0d exp data=a5 goon=1 occ=1",
               a_data, a_goon, a_occ);
    end
    pre_valid = 1'b0;
    step();
    idle_drain(2);
  endtask

  task automatic test_backpressure();
    post_allowin = 1'b0; pre_valid = 1'b1; src = 64'h1;
    for (int i = 0; i < 4; i++) begin
      pre_data64 = src;
      step();
      if (last_acc) src++;
    end
    checks++;
    if (a_occ !== 2'(CAP) || a_allow !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_full got occ=%0d allow=%b exp occ=%0d allow=0",
               a_occ, a_allow, CAP);
    end
    post_allowin = 1'b1;
    for (int i = 0; i < 20 && src <= 64'h4; i++) begin
      pre_data64 = src;
      step();
      if (last_acc) src++;
    end
    idle_drain(3);
  endtask

  task automatic test_stall();
    pre_valid = 1'b1; pre_data64 = 64'h11;
    step();
    cur_stall = 1'b1; pre_data64 = 64'h22;
    for (int i = 0; i < 3; i++) begin
      step();
      if (last_acc) pre_valid = 1'b0;
    end
    checks++;
    if (a_goon !== 1'b0 || a_regv !== 1'b1 || a_data !== 32'h11) begin
      errors++;
      $display("FAIL stall_hold got goon=%b regv=%b data=%h exp goon=0 regv=1 data=11",
               a_goon, a_regv, a_data);
    end
    checks++;
    if (a_occ !== 2'(CAP)) begin
      errors++;
      $display("FAIL stall_occ got=%0d exp=%0d", a_occ, CAP);
    end
    idle_drain(3);
  endtask

  task automatic test_flush();
    post_allowin = 1'b0; pre_valid = 1'b1;
    pre_data64 = 64'h31;
    step();
    pre_data64 = 64'h32;
    step();
    flush = 1'b1; pre_data64 = 64'h77;
    step();
    flush = 1'b0; pre_valid = 1'b0;
    #1;
    checks++;
    if (a_occ !== 2'd0 || a_goon !== 1'b0) begin
      errors++;
      $display("FAIL flush got occ=%0d goon=%b exp occ=0 goon=0", a_occ, a_goon);
    end
    idle_drain(3);
  endtask

  task automatic test_toggle();
    src = 64'h100; pre_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      post_allowin = (i % 2) == 1;
      pre_data64 = src;
      step();
      if (last_acc) src++;
    end
    idle_drain(3);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      resetn       = ($urandom_range(0, 49) != 0);
      flush        = ($urandom_range(0, 19) == 0);
      cur_stall    = ($urandom_range(0, 3) == 0);
      pre_valid    = $urandom_range(0, 1) == 1;
      post_allowin = $urandom_range(0, 2) != 0;
      pre_data64   = {$urandom, $urandom};
      step();
    end
    resetn = 1'b1;
    idle_drain(3);
  endtask

  task automatic test_reset_mid();
    post_allowin = 1'b0; pre_valid = 1'b1;
    pre_data64 = 64'h41;
    step();
    pre_data64 = 64'h42;
    step();
    post_allowin = 1'b1; resetn = 1'b0; pre_data64 = 64'h43;
    step();
    resetn = 1'b1; pre_valid = 1'b0;
    #1;
    checks++;
    if (a_occ !== 2'd0 || a_goon !== 1'b0 || a_regv !== 1'b0 || a_data !== RST64[31:0]) begin
      errors++;
      $display("FAIL reset_mid32 got occ=%0d goon=%b regv=%b data=%h", a_occ, a_goon, a_regv,
               a_data);
    end
    checks++;
    if (b_occ !== 2'd0 || b_goon !== 1'b0 || b_regv !== 1'b0 || b_data !== RST64[0:0]) begin
      errors++;
      $display("FAIL reset_mid_w1 got occ=%0d goon=%b regv=%b data=%b", b_occ, b_goon, b_regv,
               b_data);
    end
    checks++;
    if (c_occ !== 2'd0 || c_goon !== 1'b0 || c_regv !== 1'b0 || c_data !== RST64) begin
      errors++;
      $display("FAIL reset_mid_w64 got occ=%0d goon=%b regv=%b data=%h", c_occ, c_goon, c_regv,
               c_data);
    end
    checks++;
    if (a_allow !== 1'b1 || b_allow !== 1'b1 || c_allow !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_allow got %b%b%b exp 111", a_allow, b_allow, c_allow);
    end
    step();
    idle_drain(2);
  endtask

  initial begin
    test_reset();
    test_first_entry();
    test_backpressure();
    test_stall();
    test_flush();
    test_toggle();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 Parameter DATA_W, default 32: payload width in bits, legal range 1..1024.
REQ-002 Parameter RST_DATA, default 0: DATA_W-bit value loaded into payload registers at reset.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 resetn  in  1  reset, synchronous, active-low.
REQ-005 cur_stall  in  1  stage not ready to issue; holds the head entry.
REQ-006 flush  in  1  synchronous kill of all entries held by the stage.
REQ-007 pre_valid  in  1  upstream entry valid.
REQ-008 pre_data  in  DATA_W  upstream payload.
REQ-009 cur_allowin  out  1  stage accepts an entry this cycle.
REQ-010 post_allowin  in  1  downstream accepts an entry this cycle.
REQ-011 goon_valid  out  1  head entry offered downstream.
REQ-012 reg_valid  out  1  head entry present, regardless of stall.
REQ-013 data  out  DATA_W  head payload.
REQ-014 occupancy  out  2  number of held entries (0..2).

Function
REQ-015 Storage is a head slot H (valid hv, payload hd) and, when skid is compiled in, a skid slot S (sv, sd); invariant: sv=1 implies hv=1.
REQ-016 The stage accepts (accept) when pre_valid && cur_allowin; it issues (issue) when goon_valid && post_allowin.
REQ-017 goon_valid = hv && !cur_stall; reg_valid = hv; data = hd; occupancy = hv + sv.
REQ-018 On issue or when hv=0: H loads from S if sv=1, else from pre_data on accept, else hv clears.
REQ-019 When H loads from S and accept is also true in the same cycle, S loads pre_data and sv stays 1; otherwise sv clears.
REQ-020 When hv=1, no issue and accept: S loads pre_data and sv sets.
REQ-021 Payload registers load only on a load event; they hold their value otherwise, including when the valid bit clears.
REQ-022 Latency: an entry accepted into an empty stage appears on data/goon_valid in the next cycle; steady throughput is one entry per cycle.
REQ-023 Simultaneous issue and accept with occupancy 1 keeps occupancy 1 and keeps order (FIFO order always preserved).
REQ-024 flush=1 clears hv and sv on the next edge, overrides accept and issue, and drops any entry offered in that cycle; cur_allowin is not gated by flush.
REQ-025 cur_stall=1 never blocks accept while a free slot exists.

Reset
REQ-026 When resetn=0 at an edge: hv=0, sv=0, hd=sd=RST_DATA; therefore reg_valid=0, goon_valid=0, occupancy=0, data=RST_DATA, and cur_allowin=1 from the next cycle.
REQ-027 Reset asserted mid-transfer discards all entries and takes priority over flush, accept and issue.

Configuration
REQ-028 Macro PIPE_STAGE_SKID_EN defined: S exists; cur_allowin = !sv, a registered signal with no combinational path from post_allowin or cur_stall.
REQ-029 Macro PIPE_STAGE_SKID_EN undefined: S and its logic are absent; sv is constant 0; cur_allowin = !hv || (!cur_stall && post_allowin); occupancy never exceeds 1.

Structure
REQ-030 Shared package pipe_pkg holds the default DATA_W, the occupancy width, and the named constants OCC_EMPTY=0, OCC_ONE=1 and OCC_FULL=2.
REQ-031 Sub-module pipe_slot (valid bit, DATA_W payload, load enable, clear, reset value) is instantiated once for H and once for S (S only when skid is compiled in).

Verification
REQ-032 Reset then pre_valid=1 with pre_data=0xA5 and post_allowin=1 -> data=0xA5 and goon_valid=1 one cycle later; occupancy=1.
REQ-033 Skid on, post_allowin=0, four back-to-back offers 0x1..0x4 -> 0x1 and 0x2 accepted, cur_allowin=0 from cycle 2, occupancy=2; then post_allowin=1 -> issue order 0x1, 0x2, 0x3, 0x4 with no loss.
REQ-034 cur_stall=1 for three cycles while hv=1 -> goon_valid=0, reg_valid=1, data held; skid on: one further entry is accepted.
REQ-035 Occupancy 2 with flush=1 and pre_valid=1 (0x77) -> next cycle occupancy=0, goon_valid=0, and 0x77 never issues.
REQ-036 Skid off, hv=1, post_allowin toggling every cycle with continuous input -> cur_allowin tracks post_allowin in the same cycle; issued sequence is contiguous and in order.
REQ-037 resetn=0 while occupancy=2 and post_allowin=1 -> no issue in that cycle; next cycle all outputs hold their reset values; run for DATA_W=1 and DATA_W=64.
